// File: rtl/noc_pkt_pkg.sv
// Shared definitions for the 2-flit NoC packet format: width helpers,
// flit control bit positions and the translator FSM state encoding.
package noc_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        TAIL = 2'd2
    } pkt_state_t;

    function automatic int flit_width(input int width_pkt);
        return width_pkt / 2;
    endfunction

    function automatic int data_idl_width(input int width_pkt, input int vc_w, input int addr_w);
        return width_pkt - 6 - 2 * vc_w - addr_w;
    endfunction

    function automatic int head_data_width(input int width_pkt, input int vc_w, input int addr_w);
        return flit_width(width_pkt) - 3 - vc_w - addr_w;
    endfunction

    function automatic int tail_data_width(input int width_pkt, input int vc_w);
        return flit_width(width_pkt) - 3 - vc_w;
    endfunction

    // Control bits occupy the three MSBs of every flit.
    function automatic int flit_valid_bit(input int width_flit);
        return width_flit - 1;
    endfunction

    function automatic int flit_head_bit(input int width_flit);
        return width_flit - 2;
    endfunction

    function automatic int flit_tail_bit(input int width_flit);
        return width_flit - 3;
    endfunction

endpackage

// File: rtl/pkt_flit_builder.sv
// Combinational formation of the head and tail flits of a 2-flit packet
// from one payload word, its destination router address and VC id.
module pkt_flit_builder
    import noc_pkt_pkg::*;
#(
    parameter int WIDTH_PKT        = 36,
    parameter int WIDTH_DATA       = 12,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int ADDRESS_WIDTH    = 4
) (
    input  logic [WIDTH_DATA-1:0]       data,
    input  logic [ADDRESS_WIDTH-1:0]    dest,
    input  logic [VC_ADDRESS_WIDTH-1:0] vc,
    output logic [WIDTH_PKT/2-1:0]      head_flit,
    output logic [WIDTH_PKT/2-1:0]      tail_flit
);

    localparam int WIDTH_FLIT     = flit_width(WIDTH_PKT);
    localparam int WIDTH_DATA_IDL = data_idl_width(WIDTH_PKT, VC_ADDRESS_WIDTH, ADDRESS_WIDTH);
    localparam int HEAD_DATA_W    = head_data_width(WIDTH_PKT, VC_ADDRESS_WIDTH, ADDRESS_WIDTH);
    localparam int TAIL_DATA_W    = tail_data_width(WIDTH_PKT, VC_ADDRESS_WIDTH);
    localparam int EXTRA_BITS     = WIDTH_DATA_IDL - WIDTH_DATA;
    localparam int FLIT_VALID     = flit_valid_bit(WIDTH_FLIT);
    localparam int FLIT_HEAD      = flit_head_bit(WIDTH_FLIT);
    localparam int FLIT_TAIL      = flit_tail_bit(WIDTH_FLIT);

    logic [WIDTH_DATA_IDL-1:0] full;

    // Payload is MSB-aligned in the idealised data field; padding sits at the bottom.
    generate
        if (EXTRA_BITS > 0) begin : g_pad
            assign full = {data, {EXTRA_BITS{1'b0}}};
        end else begin : g_nopad
            assign full = data;
        end
    endgenerate

    always_comb begin
        head_flit = {3'b000, vc, dest, full[WIDTH_DATA_IDL-1 -: HEAD_DATA_W]};
        head_flit[FLIT_VALID] = 1'b1;
        head_flit[FLIT_HEAD]  = 1'b1;

        tail_flit = {3'b000, vc, full[TAIL_DATA_W-1:0]};
        tail_flit[FLIT_VALID] = 1'b1;
        tail_flit[FLIT_TAIL]  = 1'b1;
    end

endmodule

// File: rtl/packetizer_2_serial.sv
// Transmit-side translator: wraps one payload word into a head+tail flit
// pair and issues it through a registered ready/valid flit port.
module packetizer_2_serial
    import noc_pkt_pkg::*;
#(
    parameter int WIDTH_PKT        = 36,
    parameter int WIDTH_DATA       = 12,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int ADDRESS_WIDTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH_DATA-1:0]       data_in,
    input  logic [ADDRESS_WIDTH-1:0]    dest_in,
    input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    output logic [WIDTH_PKT/2-1:0]      flit_out,
    output logic                        flit_valid_out,
    input  logic                        flit_ready_in,
    output logic [15:0]                 pkt_count
);

    localparam int WIDTH_FLIT = flit_width(WIDTH_PKT);

    pkt_state_t            state_reg, state_next;
    logic [WIDTH_FLIT-1:0] flit_reg, flit_next;
    logic                  flit_valid_reg, flit_valid_next;
    logic [WIDTH_FLIT-1:0] tail_hold_reg, tail_hold_next;
    logic [15:0]           pkt_count_reg, pkt_count_next;

    logic [WIDTH_FLIT-1:0] head_flit;
    logic [WIDTH_FLIT-1:0] tail_flit;
    logic                  accept;

    pkt_flit_builder #(
        .WIDTH_PKT        (WIDTH_PKT),
        .WIDTH_DATA       (WIDTH_DATA),
        .VC_ADDRESS_WIDTH (VC_ADDRESS_WIDTH),
        .ADDRESS_WIDTH    (ADDRESS_WIDTH)
    ) u_builder (
        .data      (data_in),
        .dest      (dest_in),
        .vc        (vc_in),
        .head_flit (head_flit),
        .tail_flit (tail_flit)
    );

    // Accepting while the tail drains lets packets go back-to-back at 2 cycles each.
    assign ready_out = (state_reg == IDLE) | ((state_reg == TAIL) & flit_ready_in);
    assign accept    = valid_in & ready_out;

    always_comb begin
        state_next      = state_reg;
        flit_next       = flit_reg;
        flit_valid_next = flit_valid_reg;
        tail_hold_next  = tail_hold_reg;
        pkt_count_next  = pkt_count_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    flit_next       = head_flit;
                    tail_hold_next  = tail_flit;
                    flit_valid_next = 1'b1;
                    state_next      = HEAD;
                end else begin
                    flit_valid_next = 1'b0;
                end
            end
            HEAD: begin
                if (flit_ready_in) begin
                    flit_next  = tail_hold_reg;
                    state_next = TAIL;
                end
            end
            TAIL: begin
                if (flit_ready_in) begin
                    pkt_count_next = pkt_count_reg + 16'd1;
                    if (accept) begin
                        flit_next      = head_flit;
                        tail_hold_next = tail_flit;
                        state_next     = HEAD;
                    end else begin
                        flit_valid_next = 1'b0;
                        state_next      = IDLE;
                    end
                end
            end
            default: begin
                flit_valid_next = 1'b0;
                state_next      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            flit_reg       <= '0;
            flit_valid_reg <= 1'b0;
            tail_hold_reg  <= '0;
            pkt_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            flit_reg       <= flit_next;
            flit_valid_reg <= flit_valid_next;
            tail_hold_reg  <= tail_hold_next;
            pkt_count_reg  <= pkt_count_next;
        end
    end

    assign flit_out       = flit_reg;
    assign flit_valid_out = flit_valid_reg;
    assign pkt_count      = pkt_count_reg;

endmodule

// File: tb/tb_packetizer_2_serial.sv
// Directed checks of packetizer_2_serial: single packet, backpressure,
// back-to-back stream, mid-packet reset and a randomised loopback decode.
module tb_packetizer_2_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] data_in;
    logic [3:0]  dest_in;
    logic [0:0]  vc_in;
    logic        valid_in;
    logic        ready_out;
    logic [17:0] flit_out;
    logic        flit_valid_out;
    logic        flit_ready_in;
    logic [15:0] pkt_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [11:0] data;
        logic [3:0]  dest;
        logic        vc;
    } word_t;

    word_t       q[$];
    word_t       front;
    logic [17:0] saved_head;
    logic [17:0] prev_flit;
    logic [11:0] rec_data;
    logic [11:0] w;
    bit          expect_head;
    bit          prev_stall;
    bit          exp_ready;
    bit          vi;
    int          exp_cnt;

    always #5 clk = ~clk;

    packetizer_2_serial dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .dest_in        (dest_in),
        .vc_in          (vc_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .flit_out       (flit_out),
        .flit_valid_out (flit_valid_out),
        .flit_ready_in  (flit_ready_in),
        .pkt_count      (pkt_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            $display("PASS %s: observed %0h", tag, obs);
        end
    endtask

    // Head carries data[11:2] under dest; tail carries data[1:0] at the top of its 14-bit field.
    function automatic logic [17:0] exp_head(input logic [11:0] d, input logic [3:0] a, input logic v);
        return 18'h30000 | (18'(v) << 14) | (18'(a) << 10) | 18'(d >> 2);
    endfunction

    function automatic logic [17:0] exp_tail(input logic [11:0] d, input logic v);
        return 18'h28000 | (18'(v) << 14) | (18'(d & 12'h003) << 12);
    endfunction

    initial begin
        #1000000;
        n_fail++;
        $error("FAIL timeout: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        rst_n = 1'b0; data_in = '0; dest_in = '0; vc_in = '0;
        valid_in = 1'b0; flit_ready_in = 1'b0;
        tick(); tick();
        check("rst_valid", flit_valid_out, 1'b0);
        check("rst_flit", flit_out, 18'h0);
        check("rst_count", pkt_count, 16'h0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", ready_out, 1'b1);

        // Single packet, no backpressure
        data_in = 12'hABC; dest_in = 4'h5; vc_in = 1'b0; valid_in = 1'b1; flit_ready_in = 1'b1;
        tick();
        check("t1_head", flit_out, 18'h316AF);
        check("t1_head_v", flit_valid_out, 1'b1);
        valid_in = 1'b0;
        tick();
        check("t1_tail", flit_out, 18'h28000);
        check("t1_tail_v", flit_valid_out, 1'b1);
        check("t1_cnt_mid", pkt_count, 16'd0);
        tick();
        check("t1_idle_v", flit_valid_out, 1'b0);
        check("t1_cnt", pkt_count, 16'd1);
        check("t1_hold", flit_out, 18'h28000);

        // Backpressure in HEAD then TAIL
        data_in = 12'hABC; dest_in = 4'h5; vc_in = 1'b0; valid_in = 1'b1; flit_ready_in = 1'b0;
        tick();
        valid_in = 1'b1; data_in = 12'h111;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_head_hold", flit_out, 18'h316AF);
            check("t2_head_v", flit_valid_out, 1'b1);
            check("t2_ready_lo", ready_out, 1'b0);
            tick();
        end
        valid_in = 1'b0;
        flit_ready_in = 1'b1;
        tick();
        check("t2_tail", flit_out, 18'h28000);
        flit_ready_in = 1'b0;
        #1;
        check("t2_tail_ready_lo", ready_out, 1'b0);
        tick();
        check("t2_tail_hold", flit_out, 18'h28000);
        check("t2_tail_v", flit_valid_out, 1'b1);
        check("t2_cnt_held", pkt_count, 16'd1);
        flit_ready_in = 1'b1;
        #1;
        check("t2_tail_ready_hi", ready_out, 1'b1);
        tick();
        check("t2_idle_v", flit_valid_out, 1'b0);
        check("t2_cnt", pkt_count, 16'd2);

        // Back-to-back: 10 packets, 20 flits without bubbles
        flit_ready_in = 1'b1;
        w = 12'h123;
        data_in = w; dest_in = 4'd0; vc_in = 1'b0; valid_in = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            w = 12'((i + 1) * 12'h123);
            check("t3_head", flit_out, exp_head(w, 4'(i), 1'(i)));
            check("t3_head_v", flit_valid_out, 1'b1);
            if (i < 9) begin
                data_in = 12'((i + 2) * 12'h123); dest_in = 4'(i + 1); vc_in = 1'(i + 1);
            end else begin
                valid_in = 1'b0;
            end
            tick();
            check("t3_tail", flit_out, exp_tail(w, 1'(i)));
            check("t3_tail_v", flit_valid_out, 1'b1);
            tick();
        end
        check("t3_idle_v", flit_valid_out, 1'b0);
        check("t3_cnt", pkt_count, 16'd12);

        // Reset while the tail is on the port
        data_in = 12'hABC; dest_in = 4'h5; vc_in = 1'b0; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        check("t4_pre_tail", flit_out, 18'h28000);
        rst_n = 1'b0;
        #1;
        check("t4_rst_v", flit_valid_out, 1'b0);
        check("t4_rst_cnt", pkt_count, 16'd0);
        check("t4_rst_flit", flit_out, 18'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_no_tail", flit_valid_out, 1'b0);
        end
        data_in = 12'h5A5; dest_in = 4'hA; vc_in = 1'b1; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check("t4_head", flit_out, 18'h36969);
        tick();
        check("t4_tail", flit_out, 18'h2D000);
        tick();
        check("t4_cnt", pkt_count, 16'd1);

        // Random handshakes with a decoding scoreboard
        exp_cnt = 1; expect_head = 1'b1; prev_stall = 1'b0; prev_flit = flit_out;
        for (int i = 0; i < 600; i++) begin
            if (prev_stall) begin
                check("r_stall_flit", flit_out, prev_flit);
                check("r_stall_v", flit_valid_out, 1'b1);
            end
            vi = (i < 590) ? 1'($urandom_range(0, 1)) : 1'b0;
            flit_ready_in = (i < 590) ? ($urandom_range(0, 3) != 0) : 1'b1;
            valid_in = vi;
            data_in = 12'($urandom); dest_in = 4'($urandom); vc_in = 1'($urandom);
            #1;
            exp_ready = !flit_valid_out || (flit_out[15] && flit_ready_in);
            check("r_ready", ready_out, exp_ready);
            if (vi && exp_ready) q.push_back('{data: data_in, dest: dest_in, vc: vc_in[0]});
            if (flit_valid_out && flit_ready_in) begin
                if (expect_head) begin
                    check("r_head_ctl", flit_out[17:15], 3'b110);
                    saved_head = flit_out;
                    expect_head = 1'b0;
                end else begin
                    check("r_tail_ctl", flit_out[17:15], 3'b101);
                    check("r_tail_pad", flit_out[11:0], 12'h000);
                    if (q.size() == 0) begin
                        check("r_q_nonempty", q.size(), 1);
                    end else begin
                        front = q.pop_front();
                        rec_data = {saved_head[9:0], flit_out[13:12]};
                        check("r_data", rec_data, front.data);
                        check("r_dest", saved_head[13:10], front.dest);
                        check("r_head_vc", saved_head[14], front.vc);
                        check("r_tail_vc", flit_out[14], front.vc);
                    end
                    exp_cnt++;
                    expect_head = 1'b1;
                end
            end
            prev_stall = flit_valid_out && !flit_ready_in;
            prev_flit = flit_out;
            tick();
        end
        check("r_q_empty", q.size(), 0);
        check("r_idle_v", flit_valid_out, 1'b0);
        check("r_cnt", pkt_count, 16'(exp_cnt));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
